// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser: paces 5/10-cent coin ejection for a change code and tracks tube inventory
//   clk, rst           : clock, asynchronous active-high reset
//   chg_valid/chg_code : change request, code in 5-cent units (0..3)
//   chg_ready, busy    : idle / dispensing indication, decoded from the state register
//   refill_5/refill_10 : reload the matching tube count to TUBE_DEPTH
//   eject_5/eject_10   : solenoid drives, one PULSE_CYCLES pulse per coin then GAP_CYCLES off
//   short_err          : sticky, set when a request could not be paid in full
//   cnt_5/cnt_10       : coins remaining in each tube
//   exact_change       : cnt_5 < 2 when CHG_EXACT_CHANGE_EN is defined, otherwise 0
module vm_change_dispenser #(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int TUBE_DEPTH   = 15,
   parameter int CNT_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chg_valid,
   input  logic [1:0]       chg_code,
   output logic             chg_ready,
   input  logic             refill_5,
   input  logic             refill_10,
   output logic             eject_5,
   output logic             eject_10,
   output logic             busy,
   output logic             short_err,
   output logic [CNT_W-1:0] cnt_5,
   output logic [CNT_W-1:0] cnt_10,
   output logic             exact_change
);
   typedef enum logic [1:0] {IDLE, SELECT, PULSE, GAP} state_t;
   localparam int TMAX = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
   localparam int TW = $clog2(TMAX + 1);
   state_t state_q, state_d;
   logic [1:0] remaining_q, remaining_d;
   logic coin_sel_q, coin_sel_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] cnt_5_q, cnt_5_d, cnt_10_q, cnt_10_d;
   logic short_err_q, short_err_d;
   logic dec_5, dec_10;
   // coin_sel_q: 1 = 10-cent tube, 0 = 5-cent tube
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      coin_sel_d  = coin_sel_q;
      timer_d     = timer_q;
      short_err_d = short_err_q;
      dec_5       = 1'b0;
      dec_10      = 1'b0;
      case (state_q)
         IDLE: if (chg_valid && chg_code != 2'd0) begin
            remaining_d = chg_code;
            short_err_d = 1'b0;
            state_d     = SELECT;
         end
         SELECT: if (remaining_q >= 2'd2 && cnt_10_q != '0) begin
            coin_sel_d  = 1'b1;
            dec_10      = 1'b1;
            remaining_d = remaining_q - 2'd2;
            timer_d     = TW'(PULSE_CYCLES - 1);
            state_d     = PULSE;
         end else if (remaining_q != 2'd0 && cnt_5_q != '0) begin
            coin_sel_d  = 1'b0;
            dec_5       = 1'b1;
            remaining_d = remaining_q - 2'd1;
            timer_d     = TW'(PULSE_CYCLES - 1);
            state_d     = PULSE;
         end else begin
            // a nonzero remainder here cannot be paid and is dropped
            short_err_d = short_err_q | (remaining_q != 2'd0);
            remaining_d = 2'd0;
            state_d     = IDLE;
         end
         PULSE: begin
            timer_d = timer_q == '0 ? TW'(GAP_CYCLES - 1) : timer_q - TW'(1);
            state_d = timer_q == '0 ? GAP : PULSE;
         end
         GAP: begin
            timer_d = timer_q == '0 ? timer_q : timer_q - TW'(1);
            state_d = timer_q == '0 ? SELECT : GAP;
         end
      endcase
      // refill wins over a same-cycle decrement of the same tube
      cnt_5_d  = refill_5  ? CNT_W'(TUBE_DEPTH) : cnt_5_q  - CNT_W'(dec_5);
      cnt_10_d = refill_10 ? CNT_W'(TUBE_DEPTH) : cnt_10_q - CNT_W'(dec_10);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= 2'd0;
         coin_sel_q  <= 1'b0;
         timer_q     <= '0;
         cnt_5_q     <= '0;
         cnt_10_q    <= '0;
         short_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         coin_sel_q  <= coin_sel_d;
         timer_q     <= timer_d;
         cnt_5_q     <= cnt_5_d;
         cnt_10_q    <= cnt_10_d;
         short_err_q <= short_err_d;
      end
   end
   // outputs decode the state register, so reset clears the ejects at once
   assign chg_ready = state_q == IDLE;
   assign busy      = ~chg_ready;
   assign eject_10  = state_q == PULSE && coin_sel_q;
   assign eject_5   = state_q == PULSE && !coin_sel_q;
   assign short_err = short_err_q;
   assign cnt_5     = cnt_5_q;
   assign cnt_10    = cnt_10_q;
`ifdef CHG_EXACT_CHANGE_EN
   assign exact_change = cnt_5_q < CNT_W'(2);
`else
   assign exact_change = 1'b0;
`endif
endmodule

// File: tb/tb_vm_change_dispenser.sv
// tb_vm_change_dispenser: table-driven and directed checks of vm_change_dispenser
module tb_vm_change_dispenser;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chg_valid = 1'b0;
   logic [1:0] chg_code = 2'd0;
   logic refill_5 = 1'b0;
   logic refill_10 = 1'b0;
   logic chg_ready, eject_5, eject_10, busy, short_err, exact_change;
   logic [3:0] cnt_5, cnt_10;
   int tests = 0;
   int fails = 0;

   vm_change_dispenser dut (
      .clk(clk), .rst(rst), .chg_valid(chg_valid), .chg_code(chg_code),
      .chg_ready(chg_ready), .refill_5(refill_5), .refill_10(refill_10),
      .eject_5(eject_5), .eject_10(eject_10), .busy(busy), .short_err(short_err),
      .cnt_5(cnt_5), .cnt_10(cnt_10), .exact_change(exact_change)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, v;
      logic [1:0] code;
      logic r5, r10;
      logic rdy, e5, e10, se;
      logic [3:0] c5, c10;
   } vec_t;
   vec_t vt[$];

   function automatic logic exp_ex(input logic [3:0] c5);
`ifdef CHG_EXACT_CHANGE_EN
      return c5 < 4'd2;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [13:0] expv(input logic rdy, e5, e10, se, input logic [3:0] c5, c10);
      return {rdy, !rdy, e5, e10, se, exp_ex(c5), c5, c10};
   endfunction

   function automatic logic [13:0] outs();
      return {chg_ready, busy, eject_5, eject_10, short_err, exact_change, cnt_5, cnt_10};
   endfunction

   task automatic check(input string nm, input logic [13:0] got, input logic [13:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // n rows: inputs driven after the row's outputs are checked at the negedge
   task automatic add(input int n, input logic r, v, input logic [1:0] code, input logic r5, r10,
                      input logic rdy, e5, e10, se, input logic [3:0] c5, c10);
      for (int k = 0; k < n; k++) vt.push_back('{r, v, code, r5, r10, rdy, e5, e10, se, c5, c10});
   endtask

   initial begin
      // A: refill_10, code 2 -> one 10-cent pulse
      add(1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
      add(1, 0, 1, 2, 0, 0,  1, 0, 0, 0, 0, 15);
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 15);
      add(4, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 14);
      add(3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 14);
      add(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 14);
      // B: refill_5 only, code 2 -> two 5-cent pulses
      add(1, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0);
      add(1, 0, 1, 2, 0, 0,  1, 0, 0, 0, 15, 0);
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 15, 0);
      add(4, 0, 0, 0, 0, 0,  0, 1, 0, 0, 14, 0);
      add(3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 14, 0);
      add(4, 0, 0, 0, 0, 0,  0, 1, 0, 0, 13, 0);
      add(3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 13, 0);
      add(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 13, 0);
      // C: empty tubes, code 3 -> short; code 0 keeps it; code 1 clears then shorts again
      add(1, 0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);
      add(1, 0, 1, 1, 0, 0,  1, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);

      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         check($sformatf("row%0d", i), outs(),
               expv(vt[i].rdy, vt[i].e5, vt[i].e10, vt[i].se, vt[i].c5, vt[i].c10));
         rst = vt[i].rst; chg_valid = vt[i].v; chg_code = vt[i].code;
         refill_5 = vt[i].r5; refill_10 = vt[i].r10;
      end

      // refill_10 during SELECT overrides the decrement
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; refill_10 = 1'b1;
      @(negedge clk);
      refill_10 = 1'b0; chg_valid = 1'b1; chg_code = 2'd2;
      @(negedge clk);
      chg_valid = 1'b0;
      begin
         int n = 0;
         while (!chg_ready && n < 40) begin @(negedge clk); n++; end
      end
      check("first_dispense_done", outs(), expv(1, 0, 0, 0, 0, 14));
      chg_valid = 1'b1; chg_code = 2'd2;
      @(negedge clk);
      chg_valid = 1'b0; refill_10 = 1'b1;
      check("override_select", outs(), expv(0, 0, 0, 0, 0, 14));
      @(negedge clk);
      refill_10 = 1'b0;
      check("override_pulse", outs(), expv(0, 0, 1, 0, 0, 15));

      // async reset in the third pulse cycle
      @(posedge clk);
      @(posedge clk);
      #2;
      check("pulse3_before_rst", outs(), expv(0, 0, 1, 0, 0, 15));
      rst = 1'b1;
      #1;
      check("async_rst_drop", outs(), expv(1, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("after_rst", outs(), expv(1, 0, 0, 0, 0, 0));
      @(negedge clk);
      check("after_rst_idle", outs(), expv(1, 0, 0, 0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vm_change_dispenser.md
# vm_change_dispenser

Change-dispensing back end for the vending machine controller. It consumes the 2-bit change code the controller produces and drives the coin-ejector solenoids for the 5-cent and 10-cent tubes. It paces each ejection as a timed pulse and tracks per-tube inventory. It flags when the requested change cannot be paid in full.

## Interface
Parameters:
- PULSE_CYCLES, 4: eject solenoid on-time per coin, in clocks (≥1)
- GAP_CYCLES, 2: mandatory off-time after each pulse, in clocks (≥1)
- TUBE_DEPTH, 15: count loaded on refill (≤ 2^CNT_W−1)
- CNT_W, 4: inventory counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- chg_valid  in  1  change request present
- chg_code  in  2  change owed in 5-cent units (0..3)
- chg_ready  out  1  block can accept a request
- refill_5  in  1  load 5-cent tube count to TUBE_DEPTH
- refill_10  in  1  load 10-cent tube count to TUBE_DEPTH
- eject_5  out  1  5-cent solenoid drive
- eject_10  out  1  10-cent solenoid drive
- busy  out  1  dispensing in progress (state ≠ IDLE)
- short_err  out  1  last request underpaid (sticky)
- cnt_5  out  CNT_W  5-cent coins in tube
- cnt_10  out  CNT_W  10-cent coins in tube
- exact_change  out  1  low-change indicator (see Configuration)

## Operation
- States: IDLE, SELECT, PULSE, GAP. Register `remaining` holds 2 bits. Register `coin_sel` records which tube is being ejected.
- IDLE:
  - chg_ready=1.
  - On chg_valid with chg_code≠0, load remaining=chg_code, clear short_err, and go to SELECT.
  - On chg_valid with chg_code=0, the request is accepted and nothing happens. short_err is unchanged.
- SELECT (one cycle), evaluated in priority order:
  - remaining≥2 and cnt_10>0: select 10, decrement cnt_10, remaining−=2, go to PULSE.
  - Otherwise remaining≥1 and cnt_5>0: select 5, decrement cnt_5, remaining−=1, go to PULSE.
  - Otherwise remaining=0: go to IDLE.
  - Otherwise: set short_err=1 and go to IDLE. The unpaid remainder is dropped.
- PULSE: the selected eject output is high for exactly PULSE_CYCLES cycles. The other eject output stays low. Then go to GAP.
- GAP: both eject outputs are low for GAP_CYCLES cycles. Then go to SELECT.
- eject_5 and eject_10 are never high in the same cycle.
- Refill:
  - Accepted in any state.
  - Refill overrides a same-cycle SELECT decrement of the same tube; the count becomes TUBE_DEPTH.
  - Both refills may be asserted in the same cycle.
- Counters never wrap. Decrement only occurs when the count is >0.
- Reset values: state IDLE, chg_ready=1, eject_5=eject_10=0, busy=0, short_err=0, cnt_5=cnt_10=0, remaining=0.
- Reset mid-pulse drops the eject outputs immediately (asynchronously). The interrupted request is lost.

## Timing
- Acceptance occurs at edge E0. Cycles are numbered from E0.
  - SELECT is cycle 1.
  - The first pulse covers cycles 2..1+P.
  - The gap covers cycles 2+P..1+P+G.
  - The next SELECT is cycle 2+P+G.
- Per coin: 1+P+G cycles. The final SELECT exits to IDLE.
  - Example, defaults, code 3, both tubes stocked: eject_10 high in cycles 2–5, eject_5 high in cycles 9–12, chg_ready high again at cycle 16.
- busy = !chg_ready. Both are registered from state.
- cnt_* update at the SELECT edge, i.e. visible in the first PULSE cycle.
- short_err is set on the edge leaving the failing SELECT.

## Configuration
- CHG_EXACT_CHANGE_EN defined:
  - exact_change = (cnt_5 < 2), combinational from the counter register.
  - Warns the controller that odd change may be unpayable.
- CHG_EXACT_CHANGE_EN undefined:
  - exact_change is tied to 0.
  - No comparator is built.

## Test plan
- Reset, then release: chg_ready=1, both ejects=0, cnt_5=cnt_10=0, short_err=0, exact_change=1 (macro on) / 0 (off).
- refill_10, then code 2: eject_10 high exactly 4 cycles starting 2 cycles after accept; cnt_10 15→14; eject_5 never high; chg_ready back at cycle 9.
- refill_5 only, then code 2: two eject_5 pulses of 4 cycles separated by 3 low cycles; cnt_5 15→13; short_err=0.
- No refills, code 3: no eject pulses; short_err=1 at cycle 2; chg_ready=1 at cycle 2. A following code-0 request leaves short_err=1. A following code-1 request clears it.
- Set cnt_10=14 by refill_10 plus one code-2 dispense. Issue a second code-2 request and assert refill_10 in the same cycle as its SELECT: cnt_10 reads TUBE_DEPTH (15), not 13, in the first PULSE cycle.
- Assert rst during cycle 3 of an eject_10 pulse: eject_10 low in the same cycle; after release the state is IDLE, counts are 0, and chg_ready=1.
